// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer
//   Initiator for an external 8-bit combinational ALU. It accepts one
//   NBYTES-wide command and drives the ALU one byte per cycle, LSB first,
//   feeding each byte's status bit (ST) back in as the next carry-in (CY).
//   The full-width result and final flag are returned over valid/ready.
//   SUB is done as A + ~B + carry, because the ALU's own subtract has no
//   borrow-in.
//   Optional feature: define ALU_SEQ_ZFLAG_EN to add the res_z zero flag.
module alu_byte_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic                  cmd_cin,
   input  logic [8*NBYTES-1:0]   opa,
   input  logic [8*NBYTES-1:0]   opb,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [8*NBYTES-1:0]   res,
   output logic                  res_st,
`ifdef ALU_SEQ_ZFLAG_EN
   output logic                  res_z,
`endif
   output logic [7:0]            a,
   output logic [7:0]            b,
   output logic                  cy,
   output logic [1:0]            op,
   input  logic [7:0]            y,
   input  logic                  st
);

   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {OP_PASS = 2'b00, OP_ADD = 2'b01,
                             OP_SUB  = 2'b10, OP_CLR = 2'b11} cmd_op_t;

   state_t           state, state_nxt;
   cmd_op_t          op_q;
   logic [W-1:0]     opa_q, opb_q;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic             last_byte;
   logic [7:0]       a_byte, b_byte;
   logic [W-1:0]     res_next;

   assign last_byte = (idx == IDXW'(NBYTES - 1));
   assign cmd_ready = (state == S_IDLE);
   assign res_valid = (state == S_DONE);

   // Byte lanes of the captured operands and the result with the current
   // ALU byte merged in at the active lane.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      a_byte   = opa_q[{idx, 3'b000} +: 8];
      b_byte   = opb_q[{idx, 3'b000} +: 8];
      res_next = res;
      res_next[{idx, 3'b000} +: 8] = y;
   end

   // State register; reset aborts any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nxt = S_RUN;
         S_RUN:   if (last_byte) state_nxt = S_DONE;
         S_DONE:  if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ALU drive: parked at CLR with zero operands outside RUN.
   always_comb begin
      op = 2'b11;
      a  = 8'h00;
      b  = 8'h00;
      cy = 1'b0;
      if (state == S_RUN) begin
         case (op_q)
            OP_PASS: begin
               op = 2'b00;
               a  = a_byte;
               b  = b_byte;
            end
            OP_ADD: begin
               op = 2'b01;
               a  = a_byte;
               b  = b_byte;
               cy = carry;
            end
            OP_SUB: begin
               op = 2'b01;
               a  = a_byte;
               b  = ~b_byte;
               cy = carry;
            end
            default: ;
         endcase
      end
   end

   // Datapath: capture on accept, collect one result byte per RUN cycle,
   // latch the final flags on the last byte. Y/ST are only sampled in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_PASS;
         opa_q  <= '0;
         opb_q  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         res    <= '0;
         res_st <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
         res_z  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  opa_q <= opa;
                  opb_q <= opb;
                  op_q  <= cmd_op_t'(cmd_op);
                  idx   <= '0;
                  case (cmd_op_t'(cmd_op))
                     OP_ADD:  carry <= cmd_cin;
                     OP_SUB:  carry <= ~cmd_cin;
                     default: carry <= 1'b0;
                  endcase
               end
            end
            S_RUN: begin
               res   <= res_next;
               carry <= st;
               idx   <= idx + IDXW'(1);
               if (last_byte) begin
                  idx <= '0;
                  case (op_q)
                     OP_ADD:  res_st <= st;
                     OP_SUB:  res_st <= ~st;
                     default: res_st <= 1'b0;
                  endcase
`ifdef ALU_SEQ_ZFLAG_EN
                  res_z <= ~|res_next;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
